// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// One word per line; the backing memory is reached through a req/ack handshake.
module dcache_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int BYTE_DATA_WIDTH = 4,
    parameter int LINES           = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       data_req,
    input  logic                       data_we,
    input  logic [DATA_WIDTH-1:0]      data_addr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
    output logic                       data_valid,
    output logic [DATA_WIDTH-1:0]      rdata,
    input  logic                       flush,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [DATA_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    output logic [BYTE_DATA_WIDTH-1:0] mem_be,
    input  logic                       mem_ack,
    input  logic [DATA_WIDTH-1:0]      mem_rdata
);

    // state | meaning
    // IDLE  | waiting for data_req; flush honoured here; hit lookup
    // FILL  | load miss, reading the word from memory
    // WRITE | store, writing through to memory
    // RESP  | data_valid pulse, back to IDLE

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_e;

    state_e                     state_q, state_d;
    logic [LINES-1:0]           valid_q, valid_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic                       data_valid_q, data_valid_d;
    logic                       mem_req_q, mem_req_d;
    logic                       mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
    logic [BYTE_DATA_WIDTH-1:0] mem_be_q, mem_be_d;

    logic [TAG_W-1:0]           tag_q  [LINES];
    logic [DATA_WIDTH-1:0]      data_q [LINES];

    logic [IDX_W-1:0]           req_idx, cur_idx;
    logic [TAG_W-1:0]           req_tag, cur_tag;
    logic [DATA_WIDTH-1:0]      req_word_addr;
    logic                       req_hit, cur_hit;
    logic [DATA_WIDTH-1:0]      merged_word;
    logic                       line_we;
    logic [DATA_WIDTH-1:0]      line_word;
    logic                       addr_unused;

    assign addr_unused   = ^data_addr[1:0];
    assign req_idx       = data_addr[IDX_W+1:2];
    assign req_tag       = data_addr[DATA_WIDTH-1:IDX_W+2];
    assign req_word_addr = {data_addr[DATA_WIDTH-1:2], 2'b00};

    // The registered memory address doubles as the captured request address.
    assign cur_idx = mem_addr_q[IDX_W+1:2];
    assign cur_tag = mem_addr_q[DATA_WIDTH-1:IDX_W+2];

    // A flush in the same IDLE cycle makes every line look invalid.
    assign req_hit = valid_q[req_idx] && !flush && (tag_q[req_idx] == req_tag);
    assign cur_hit = valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

    always_comb begin
        merged_word = data_q[cur_idx];
        for (int b = 0; b < BYTE_DATA_WIDTH; b++) begin
            if (mem_be_q[b]) begin
                merged_word[8*b +: 8] = mem_wdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        rdata_d      = rdata_q;
        data_valid_d = 1'b0;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        line_we      = 1'b0;
        line_word    = mem_rdata;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end
                if (data_req) begin
                    mem_addr_d = req_word_addr;
                    if (data_we) begin
                        state_d     = WRITE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = wdata;
                        mem_be_d    = byte_enable;
                    end else if (req_hit) begin
                        state_d      = RESP;
                        data_valid_d = 1'b1;
                        rdata_d      = data_q[req_idx];
                    end else begin
                        state_d   = FILL;
                        mem_req_d = 1'b1;
                        mem_we_d  = 1'b0;
                        mem_be_d  = '1;
                    end
                end
            end
            FILL: begin
                if (mem_ack) begin
                    line_we          = 1'b1;
                    line_word        = mem_rdata;
                    valid_d[cur_idx] = 1'b1;
                    rdata_d          = mem_rdata;
                    mem_req_d        = 1'b0;
                    data_valid_d     = 1'b1;
                    state_d          = RESP;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    // No allocation on a store miss.
                    line_we      = cur_hit;
                    line_word    = merged_word;
                    mem_req_d    = 1'b0;
                    data_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            rdata_q      <= '0;
            data_valid_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            rdata_q      <= rdata_d;
            data_valid_q <= data_valid_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
        end
    end

    // Line payload needs no reset; validity lives in valid_q.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[cur_idx]  <= cur_tag;
            data_q[cur_idx] <= line_word;
        end
    end

    assign data_valid = data_valid_q;
    assign rdata      = rdata_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized and directed bench for dcache_ctrl against a line-level cache
// model plus a word-addressed backing memory.
module tb_dcache_ctrl;

    localparam int DW = 32;
    localparam int BW = 4;
    localparam int LN = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          data_req = 1'b0;
    logic          data_we = 1'b0;
    logic [DW-1:0] data_addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [BW-1:0] byte_enable = '0;
    logic          data_valid;
    logic [DW-1:0] rdata;
    logic          flush = 1'b0;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [BW-1:0] mem_be;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int n_checks = 0;
    int n_pass   = 0;

    dcache_ctrl #(.DATA_WIDTH(DW), .BYTE_DATA_WIDTH(BW), .LINES(LN)) dut (
        .clk(clk), .rst_n(rst_n), .data_req(data_req), .data_we(data_we),
        .data_addr(data_addr), .wdata(wdata), .byte_enable(byte_enable),
        .data_valid(data_valid), .rdata(rdata), .flush(flush),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: cache lines and backing memory
    bit            mv [LN];
    logic [25:0]   mt [LN];
    logic [31:0]   md [LN];
    logic [31:0]   mem [logic [29:0]];

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        int          lat;
        bit          ff;
        bit          fm;
        logic [31:0] k;
    } txn_t;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (!mem.exists(a[31:2])) mem[a[31:2]] = $urandom;
        return mem[a[31:2]];
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < LN; i++) mv[i] = 1'b0;
    endtask

    task automatic model_step(input bit we, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] be, input bit ff,
                              output bit exp_mem, output logic [31:0] exp_rd);
        int          idx = int'(a[5:2]);
        logic [25:0] tg  = a[31:6];
        bit          hit;
        if (ff) model_clear();
        hit = mv[idx] && (mt[idx] == tg);
        exp_rd = 'x;
        if (!we) begin
            exp_mem = !hit;
            if (hit) exp_rd = md[idx];
            else begin
                exp_rd  = mem_read(a);
                mv[idx] = 1'b1;
                mt[idx] = tg;
                md[idx] = exp_rd;
            end
        end else begin
            exp_mem = 1'b1;
            mem[a[31:2]] = merge(mem_read(a), wd, be);
            if (hit) md[idx] = merge(md[idx], wd, be);
        end
    endtask

    // Drives one request and acts as the backing memory; reports what it saw.
    task automatic run_txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be, input int lat, input bit ff, input bit fm,
                           output int cyc, output bit saw_mem, output logic [31:0] rd,
                           output bit p_we, output logic [31:0] p_addr,
                           output logic [31:0] p_wdata, output logic [3:0] p_be,
                           output bit stable, output bit dv_after);
        int waitc = 0;
        bit acked = 0;
        cyc = 0; saw_mem = 0; rd = 'x; stable = 1; dv_after = 0;
        p_we = 0; p_addr = '0; p_wdata = '0; p_be = '0;
        @(negedge clk);
        data_req = 1; data_we = we; data_addr = a; wdata = wd; byte_enable = be; flush = ff;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            mem_ack = 0;
            flush = fm;
            data_addr = $urandom; wdata = $urandom; byte_enable = 4'($urandom);
            if (acked && mem_req) stable = 0;
            if (data_valid) begin
                cyc = i;
                rd  = rdata;
                break;
            end
            if (mem_req && !acked) begin
                if (!saw_mem) begin
                    saw_mem = 1; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata; p_be = mem_be;
                end else if ({p_we, p_addr, p_wdata, p_be} !== {mem_we, mem_addr, mem_wdata, mem_be}) begin
                    stable = 0;
                end
                if (waitc == lat) begin
                    mem_ack   = 1;
                    mem_rdata = mem_we ? 32'($urandom) : mem_read(mem_addr);
                    acked     = 1;
                end else begin
                    waitc++;
                end
            end
        end
        data_req = 0; flush = 0; mem_ack = 0;
        @(negedge clk);
        dv_after = data_valid;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({data_valid, mem_req, mem_we} !== 3'b000)
            $display("FAIL reset_ctrl: got dv/req/we=%b want 000", {data_valid, mem_req, mem_we});
        else n_pass++;
        n_checks++;
        if ({rdata, mem_addr, mem_wdata, mem_be} !== '0)
            $display("FAIL reset_data: got rdata=%h maddr=%h mwdata=%h mbe=%h want zeros",
                     rdata, mem_addr, mem_wdata, mem_be);
        else n_pass++;
        @(negedge clk);
        rst_n = 1;
        model_clear();
    endtask

    task automatic test_directed();
        txn_t        tq[$];
        int          cyc;
        bit          saw, pwe, stb, dva, em;
        logic [31:0] rd, pa, pwd, er;
        logic [3:0]  pbe;
        mem[30'h4] = 32'hDEAD_BEEF;
        tq.push_back('{0, 32'h10, 32'h0,        4'h0, 3, 0, 0, 32'hDEAD_BEEF});
        tq.push_back('{0, 32'h10, 32'h0,        4'h0, 3, 0, 0, 32'hDEAD_BEEF});
        tq.push_back('{1, 32'h10, 32'h1122_3344, 4'h3, 2, 0, 0, 32'hx});
        tq.push_back('{0, 32'h12, 32'h0,        4'h0, 0, 0, 0, 32'hDEAD_3344});
        tq.push_back('{1, 32'h50, 32'hCAFE_F00D, 4'hF, 1, 0, 0, 32'hx});
        tq.push_back('{0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 32'hDEAD_3344});
        tq.push_back('{0, 32'h53, 32'h0,        4'h0, 2, 0, 0, 32'hCAFE_F00D});
        tq.push_back('{0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 32'hDEAD_3344});
        foreach (tq[t]) begin
            model_step(tq[t].we, tq[t].a, tq[t].wd, tq[t].be, tq[t].ff, em, er);
            run_txn(tq[t].we, tq[t].a, tq[t].wd, tq[t].be, tq[t].lat, tq[t].ff, tq[t].fm,
                    cyc, saw, rd, pwe, pa, pwd, pbe, stb, dva);
            n_checks++;
            if (cyc != (em ? tq[t].lat + 2 : 1))
                $display("FAIL dir%0d_latency: got %0d want %0d", t, cyc, em ? tq[t].lat + 2 : 1);
            else n_pass++;
            n_checks++;
            if (saw !== em) $display("FAIL dir%0d_mem_req: got %b want %b", t, saw, em);
            else n_pass++;
            n_checks++;
            if (dva !== 1'b0 || stb !== 1'b1)
                $display("FAIL dir%0d_pulse_stable: got dv_after=%b stable=%b want 0 1", t, dva, stb);
            else n_pass++;
            if (em) begin
                n_checks++;
                if ({pwe, pa, pbe, tq[t].we ? pwd : 32'h0} !==
                    {tq[t].we, tq[t].a & ~32'h3, tq[t].we ? tq[t].be : 4'hF, tq[t].we ? tq[t].wd : 32'h0})
                    $display("FAIL dir%0d_payload: got we=%b addr=%h be=%h wdata=%h", t, pwe, pa, pbe, pwd);
                else n_pass++;
            end
            if (!tq[t].we) begin
                n_checks++;
                if (rd !== er || rd !== tq[t].k)
                    $display("FAIL dir%0d_rdata: got %h want %h", t, rd, tq[t].k);
                else n_pass++;
            end
        end
    endtask

    task automatic test_flush();
        int          cyc;
        bit          saw, pwe, stb, dva, em;
        logic [31:0] rd, pa, pwd, er;
        logic [3:0]  pbe;
        model_step(0, 32'h10, 0, 0, 0, em, er);
        run_txn(0, 32'h10, 0, 0, 1, 0, 0, cyc, saw, rd, pwe, pa, pwd, pbe, stb, dva);
        @(negedge clk); flush = 1;
        @(negedge clk); flush = 0;
        model_clear();
        model_step(0, 32'h10, 0, 0, 0, em, er);
        run_txn(0, 32'h10, 0, 0, 2, 0, 1, cyc, saw, rd, pwe, pa, pwd, pbe, stb, dva);
        n_checks++;
        if (saw !== 1'b1 || rd !== er)
            $display("FAIL flush_idle_miss: got mem_req=%b rdata=%h want 1 %h", saw, rd, er);
        else n_pass++;
        model_step(0, 32'h10, 0, 0, 0, em, er);
        run_txn(0, 32'h10, 0, 0, 0, 0, 0, cyc, saw, rd, pwe, pa, pwd, pbe, stb, dva);
        n_checks++;
        if (saw !== 1'b0 || cyc != 1 || rd !== er)
            $display("FAIL flush_in_fill_ignored: got mem_req=%b cyc=%0d rdata=%h want 0 1 %h",
                     saw, cyc, rd, er);
        else n_pass++;
        model_step(0, 32'h10, 0, 0, 1, em, er);
        run_txn(0, 32'h10, 0, 0, 1, 1, 0, cyc, saw, rd, pwe, pa, pwd, pbe, stb, dva);
        n_checks++;
        if (saw !== 1'b1 || rd !== er)
            $display("FAIL flush_with_req_miss: got mem_req=%b rdata=%h want 1 %h", saw, rd, er);
        else n_pass++;
    endtask

    task automatic test_random();
        int          cyc, lat, fails_before;
        bit          saw, pwe, stb, dva, em, we, ff, fm;
        logic [31:0] rd, pa, pwd, er, a, wd;
        logic [3:0]  pbe, be;
        for (int t = 0; t < 300; t++) begin
            we  = ($urandom_range(0, 2) == 0);
            a   = {24'h0, 2'($urandom), 4'($urandom), 2'($urandom)};
            wd  = $urandom;
            be  = 4'($urandom);
            lat = $urandom_range(0, 3);
            ff  = ($urandom_range(0, 15) == 0);
            fm  = ($urandom_range(0, 7) == 0);
            model_step(we, a, wd, be, ff, em, er);
            run_txn(we, a, wd, be, lat, ff, fm, cyc, saw, rd, pwe, pa, pwd, pbe, stb, dva);
            fails_before = n_checks - n_pass;
            n_checks++;
            if (cyc != (em ? lat + 2 : 1) || saw !== em || dva !== 1'b0 || stb !== 1'b1)
                $display("FAIL rnd%0d_timing: cyc=%0d mem=%b dv_after=%b stable=%b want cyc=%0d mem=%b",
                         t, cyc, saw, dva, stb, em ? lat + 2 : 1, em);
            else n_pass++;
            if (em) begin
                n_checks++;
                if ({pwe, pa, pbe, we ? pwd : 32'h0} !== {we, a & ~32'h3, we ? be : 4'hF, we ? wd : 32'h0})
                    $display("FAIL rnd%0d_payload: got we=%b addr=%h be=%h wdata=%h", t, pwe, pa, pbe, pwd);
                else n_pass++;
            end
            if (!we) begin
                n_checks++;
                if (rd !== er) $display("FAIL rnd%0d_rdata: got %h want %h", t, rd, er);
                else n_pass++;
            end
            if (n_checks - n_pass > fails_before + 20) break;
        end
    endtask

    task automatic test_reset_mid_fill();
        int          cyc;
        bit          saw, pwe, stb, dva, em, seen;
        logic [31:0] rd, pa, pwd, er;
        logic [3:0]  pbe;
        model_step(0, 32'h94, 0, 0, 0, em, er);
        run_txn(0, 32'h94, 0, 0, 0, 0, 0, cyc, saw, rd, pwe, pa, pwd, pbe, stb, dva);
        model_clear();
        void'(mem_read(32'h90));
        @(negedge clk);
        data_req = 1; data_we = 0; data_addr = 32'h90;
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            @(negedge clk);
            seen = mem_req;
        end
        n_checks++;
        if (!seen) $display("FAIL rst_fill_start: got mem_req=0 want 1");
        else n_pass++;
        rst_n = 0;
        #1;
        n_checks++;
        if ({mem_req, data_valid, rdata, mem_addr} !== '0)
            $display("FAIL rst_mid_fill: got req=%b dv=%b rdata=%h maddr=%h want zeros",
                     mem_req, data_valid, rdata, mem_addr);
        else n_pass++;
        data_req = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (data_valid !== 1'b0 || mem_req !== 1'b0)
                $display("FAIL rst_after_quiet: got dv=%b req=%b want 0 0", data_valid, mem_req);
            else n_pass++;
        end
        model_step(0, 32'h90, 0, 0, 0, em, er);
        run_txn(0, 32'h90, 0, 0, 1, 0, 0, cyc, saw, rd, pwe, pa, pwd, pbe, stb, dva);
        n_checks++;
        if (saw !== 1'b1 || rd !== er)
            $display("FAIL rst_reload_miss: got mem_req=%b rdata=%h want 1 %h", saw, rd, er);
        else n_pass++;
        model_step(0, 32'h94, 0, 0, 0, em, er);
        run_txn(0, 32'h94, 0, 0, 0, 0, 0, cyc, saw, rd, pwe, pa, pwd, pbe, stb, dva);
        n_checks++;
        if (saw !== 1'b1 || rd !== er)
            $display("FAIL rst_cleared_line: got mem_req=%b rdata=%h want 1 %h", saw, rd, er);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_flush();
        test_random();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
